baud_nco_tick_gen: RTL and testbench

Parametrised fractional-N tick generator for the UART path. A phase accumulator with a runtime-programmable increment produces an oversample tick. A modulo-OVERSAMPLE counter derives from it a baud tick and a mid-bit tick. A resync input realigns phase to a detected start-bit edge, which lets the RX deserialiser and the TX serialiser share one timing source at any baud rate without resynthesis.

---
 rtl/baud_nco_tick_gen_pkg.sv | 29 ++
 rtl/baud_nco_tick_gen_if.sv | 38 +++
 rtl/baud_nco_tick_gen_nco_phase_acc.sv | 55 +++++
 rtl/baud_nco_tick_gen.sv | 85 ++++++++
 tb/tb_baud_nco_tick_gen.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/baud_nco_tick_gen_pkg.sv
// Shared constants and helpers for the UART tick generator.
// Holds the system clock rate and the increment calculation for the phase accumulator.
package uart_tick_pkg;

    // System clock feeding the tick generator.
    localparam longint unsigned CLK_HZ = 100_000_000;

    // Reference configuration for the precomputed increments below.
    localparam int unsigned REF_ACC_W      = 24;
    localparam int unsigned REF_OVERSAMPLE = 16;

    // Rounded increment: round(baud * oversample * 2^acc_w / CLK_HZ).
    // 64-bit arithmetic keeps 921600 x16 x2^24 well clear of overflow.
    function automatic longint unsigned calc_inc(
        input longint unsigned baud,
        input longint unsigned oversample,
        input int unsigned     acc_w
    );
        longint unsigned num;
        num = (baud * oversample) << acc_w;
        return (num + (CLK_HZ / 2)) / CLK_HZ;
    endfunction

    // Common baud rates at ACC_W=24, x16 oversampling.
    localparam int unsigned INC_9600   = 32'(calc_inc(9600,   REF_OVERSAMPLE, REF_ACC_W));
    localparam int unsigned INC_115200 = 32'(calc_inc(115200, REF_OVERSAMPLE, REF_ACC_W));
    localparam int unsigned INC_921600 = 32'(calc_inc(921600, REF_OVERSAMPLE, REF_ACC_W));

endpackage

// File: rtl/baud_nco_tick_gen_if.sv
// Control and tick bundle between a UART timing client and the tick generator.
// The master drives run/rate/realign controls; the slave (the generator) returns ticks.
interface baud_nco_tick_gen_if #(
    parameter int ACC_W = 24,
    parameter int IDX_W = 4
);
    logic             enable_in;
    logic [ACC_W-1:0] inc_in;
    logic             inc_load_in;
    logic             resync_in;

    logic             sample_tick_out;
    logic             baud_tick_out;
    logic             mid_bit_tick_out;
    logic [IDX_W-1:0] sample_idx_out;

    modport master (
        output enable_in,
        output inc_in,
        output inc_load_in,
        output resync_in,
        input  sample_tick_out,
        input  baud_tick_out,
        input  mid_bit_tick_out,
        input  sample_idx_out
    );

    modport slave (
        input  enable_in,
        input  inc_in,
        input  inc_load_in,
        input  resync_in,
        output sample_tick_out,
        output baud_tick_out,
        output mid_bit_tick_out,
        output sample_idx_out
    );
endinterface

// File: rtl/baud_nco_tick_gen_nco_phase_acc.sv
// Phase accumulator for the tick generator.
// Adds the programmable increment each enabled cycle and reports the carry out
// of the top bit, which is the raw oversample event. Resync zeroes the phase and
// suppresses the carry; an increment load is phase-continuous.
module nco_phase_acc #(
    parameter int               ACC_W       = 24,
    parameter logic [ACC_W-1:0] DEFAULT_INC = '0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             enable_i,
    input  logic [ACC_W-1:0] inc_i,
    input  logic             inc_load_i,
    input  logic             resync_i,
    output logic             carry_o
);

    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_d;
    logic [ACC_W-1:0] inc_q;
    logic [ACC_W-1:0] inc_d;
    logic [ACC_W:0]   sum;

    // One extra bit catches the wrap; the low bits wrap naturally.
    assign sum = {1'b0, acc_q} + {1'b0, inc_q};

    // Next phase and increment; resync wins over enable, load always honoured.
    always_comb begin
        acc_d = acc_q;
        inc_d = inc_q;
        if (resync_i) begin
            acc_d = '0;
        end else if (enable_i) begin
            acc_d = sum[ACC_W-1:0];
        end
        if (inc_load_i) begin
            inc_d = inc_i;
        end
    end

    // A carry only counts when the phase actually advanced this cycle.
    assign carry_o = enable_i & ~resync_i & sum[ACC_W];

    // Phase and increment registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            acc_q <= '0;
            inc_q <= DEFAULT_INC;
        end else begin
            acc_q <= acc_d;
            inc_q <= inc_d;
        end
    end

endmodule

// File: rtl/baud_nco_tick_gen.sv
// Fractional-N baud tick generator.
// The phase accumulator yields oversample events; a modulo-OVERSAMPLE index
// turns them into baud and mid-bit ticks. All ticks are registered one-cycle
// pulses so RX and TX can share a single timing source.
module baud_nco_tick_gen
    import uart_tick_pkg::*;
#(
    parameter int          ACC_W       = 24,
    parameter int          OVERSAMPLE  = 16,
    parameter int unsigned DEFAULT_INC = INC_115200
) (
    input  logic                clk_in,
    input  logic                rst_in,
    baud_nco_tick_gen_if.slave  bus
);

    localparam int IDX_W = $clog2(OVERSAMPLE);
    localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(OVERSAMPLE - 1);
    localparam logic [IDX_W-1:0] IDX_PRE_MID = IDX_W'(OVERSAMPLE / 2 - 1);
    localparam logic [IDX_W-1:0] IDX_ONE     = IDX_W'(1);

    // The mid-bit point only exists for an even oversample factor of at least 2.
    generate
        if ((OVERSAMPLE < 2) || ((OVERSAMPLE % 2) != 0)) begin : g_bad_oversample
            $fatal(1, "baud_nco_tick_gen: OVERSAMPLE must be even and >= 2");
        end
    endgenerate

    logic             carry;
    logic [IDX_W-1:0] cnt_q;
    logic [IDX_W-1:0] cnt_d;
    logic             sample_q;
    logic             sample_d;
    logic             baud_q;
    logic             baud_d;
    logic             mid_q;
    logic             mid_d;

    nco_phase_acc #(
        .ACC_W       (ACC_W),
        .DEFAULT_INC (ACC_W'(DEFAULT_INC))
    ) u_phase_acc (
        .clk_i      (clk_in),
        .rst_i      (rst_in),
        .enable_i   (bus.enable_in),
        .inc_i      (bus.inc_in),
        .inc_load_i (bus.inc_load_in),
        .resync_i   (bus.resync_in),
        .carry_o    (carry)
    );

    // Index advance and tick decode; carry is already gated by enable and resync.
    always_comb begin
        cnt_d = cnt_q;
        if (bus.resync_in) begin
            cnt_d = '0;
        end else if (carry) begin
            cnt_d = (cnt_q == IDX_LAST) ? '0 : cnt_q + IDX_ONE;
        end
        sample_d = carry;
        baud_d   = carry && (cnt_q == IDX_LAST);
        mid_d    = carry && (cnt_q == IDX_PRE_MID);
    end

    // Index counter and registered tick pulses.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            cnt_q    <= '0;
            sample_q <= 1'b0;
            baud_q   <= 1'b0;
            mid_q    <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            sample_q <= sample_d;
            baud_q   <= baud_d;
            mid_q    <= mid_d;
        end
    end

    assign bus.sample_tick_out  = sample_q;
    assign bus.baud_tick_out    = baud_q;
    assign bus.mid_bit_tick_out = mid_q;
    assign bus.sample_idx_out   = cnt_q;

endmodule

// File: tb/tb_baud_nco_tick_gen.sv
// Bench for baud_nco_tick_gen at ACC_W=8, OVERSAMPLE=16, DEFAULT_INC=64.
// A phase/tick-count model is compared against the DUT every cycle; a few
// directed scenarios pin literal tick positions.
module tb_baud_nco_tick_gen;

    localparam int ACC_W   = 8;
    localparam int OS      = 16;
    localparam int DEF_INC = 64;
    localparam int IDX_W   = 4;
    localparam int MODULUS = 1 << ACC_W;

    logic clk = 1'b0;
    logic rst = 1'b1;

    baud_nco_tick_gen_if #(.ACC_W(ACC_W), .IDX_W(IDX_W)) bus ();

    baud_nco_tick_gen #(
        .ACC_W       (ACC_W),
        .OVERSAMPLE  (OS),
        .DEFAULT_INC (DEF_INC)
    ) dut (
        .clk_in (clk),
        .rst_in (rst),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Model state: phase, increment, ticks-since-resync modulo OS, edge count.
    int   m_phase;
    int   m_inc;
    int   m_idx;
    int   cyc   = 0;
    bit   m_valid = 1'b0;
    bit   e_s, e_b, e_m;

    // Behavioural model: each enabled edge adds inc; crossing 2^ACC_W is a tick.
    initial begin
        int total;
        forever begin
            @(posedge clk);
            if (rst) begin
                m_phase = 0; m_idx = 0; m_inc = DEF_INC;
                e_s = 0; e_b = 0; e_m = 0;
                cyc = 0; m_valid = 1'b1;
            end else begin
                cyc++;
                e_s = 0; e_b = 0; e_m = 0;
                if (bus.resync_in) begin
                    m_phase = 0; m_idx = 0;
                end else if (bus.enable_in) begin
                    total = m_phase + m_inc;
                    if (total >= MODULUS) begin
                        e_s = 1;
                        e_b = (m_idx == OS - 1);
                        e_m = (m_idx == OS / 2 - 1);
                        m_idx = (m_idx + 1) % OS;
                    end
                    m_phase = total % MODULUS;
                end
                if (bus.inc_load_in) m_inc = int'(bus.inc_in);
            end
        end
    end

    // Per-cycle comparison of all outputs against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (m_valid) begin
                checks++;
                if (bus.sample_tick_out !== e_s || bus.baud_tick_out !== e_b ||
                    bus.mid_bit_tick_out !== e_m || bus.sample_idx_out !== IDX_W'(m_idx)) begin
                    failures++;
                    $display("FAIL cycle_outputs cyc=%0d got s=%b b=%b m=%b idx=%0d exp s=%b b=%b m=%b idx=%0d",
                             cyc, bus.sample_tick_out, bus.baud_tick_out, bus.mid_bit_tick_out,
                             bus.sample_idx_out, e_s, e_b, e_m, m_idx);
                end
            end
        end
    end

    task automatic check_int(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end else begin
            $display("ok   %s = %0d", name, got);
        end
    endtask

    task automatic do_reset();
        int outs;
        rst = 1'b1;
        bus.enable_in = 1'b1; bus.inc_load_in = 1'b0; bus.resync_in = 1'b0; bus.inc_in = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        outs = {bus.sample_tick_out, bus.baud_tick_out, bus.mid_bit_tick_out, bus.sample_idx_out};
        check_int("reset_outputs_zero", outs, 0);
    endtask

    task automatic wait_cyc(input int n);
        int guard = 0;
        while (cyc < n && guard < 5000) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (guard >= 5000) begin
            checks++; failures++;
            $display("FAIL wait_cyc_timeout target=%0d got=%0d", n, cyc);
        end
    endtask

    // Returns the edge count at the next cycle where the chosen tick is high.
    task automatic find_next(input int which, input int limit, output int at);
        bit hit;
        at = -1;
        for (int k = 0; k < limit; k++) begin
            @(negedge clk);
            hit = (which == 0) ? bus.sample_tick_out :
                  (which == 1) ? bus.mid_bit_tick_out : bus.baud_tick_out;
            if (hit) begin
                at = cyc;
                break;
            end
        end
    endtask

    task automatic count_ticks(input int n, output int c);
        c = 0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            c += int'(bus.sample_tick_out) + int'(bus.baud_tick_out) + int'(bus.mid_bit_tick_out);
        end
    endtask

    initial begin
        #(1_000_000);
        $display("FAIL watchdog_timeout cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int at;
        int c;
        int sel;
        bus.enable_in = 1'b0; bus.inc_load_in = 1'b0; bus.resync_in = 1'b0; bus.inc_in = '0;

        // Plain run from reset: period-4 sample ticks, mid at 32, baud at 64.
        do_reset();
        find_next(0, 20, at);  check_int("first_sample_tick", at, 4);
        find_next(1, 60, at);  check_int("first_mid_tick", at, 32);
        find_next(2, 60, at);  check_int("first_baud_tick", at, 64);
        find_next(2, 80, at);  check_int("second_baud_tick", at, 128);

        // Resync sampled at edge 38 (cnt=9): ticks restart from phase 0.
        do_reset();
        wait_cyc(37); bus.resync_in = 1'b1;
        wait_cyc(38); bus.resync_in = 1'b0;
        find_next(0, 20, at);  check_int("resync_next_sample", at, 42);
        find_next(2, 100, at); check_int("resync_next_baud", at, 102);

        // Freeze for edges 10..29 shifts the schedule by 20.
        do_reset();
        wait_cyc(9);  bus.enable_in = 1'b0;
        count_ticks(20, c); check_int("freeze_no_ticks", c, 0);
        wait_cyc(29); bus.enable_in = 1'b1;
        find_next(2, 200, at); check_int("freeze_baud_shift", at, 84);

        // Phase-continuous rate change to 48: exactly 48 carries per 256 cycles.
        do_reset();
        wait_cyc(19); bus.inc_in = 8'd48; bus.inc_load_in = 1'b1;
        wait_cyc(20); bus.inc_load_in = 1'b0;
        count_ticks(40, c);
        begin
            int s = 0;
            for (int k = 0; k < 256; k++) begin
                @(negedge clk);
                s += int'(bus.sample_tick_out);
            end
            check_int("inc48_ticks_per_256", s, 48);
        end

        // Zero increment freezes everything; 128 then ticks every other cycle.
        do_reset();
        wait_cyc(10); bus.inc_in = 8'd0; bus.inc_load_in = 1'b1;
        wait_cyc(11); bus.inc_load_in = 1'b0;
        count_ticks(1000, c); check_int("inc0_no_ticks", c, 0);
        @(posedge clk); #1; bus.inc_in = 8'd128; bus.inc_load_in = 1'b1;
        @(posedge clk); #1; bus.inc_load_in = 1'b0;
        repeat (3) @(negedge clk);
        begin
            int s = 0;
            for (int k = 0; k < 100; k++) begin
                @(negedge clk);
                s += int'(bus.sample_tick_out);
            end
            check_int("inc128_ticks_per_100", s, 50);
        end

        // Mid-run reset restores DEFAULT_INC; then simultaneous resync+load of 96.
        do_reset();
        wait_cyc(5);  bus.inc_in = 8'd100; bus.inc_load_in = 1'b1;
        wait_cyc(6);  bus.inc_load_in = 1'b0;
        wait_cyc(50); rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        c = {bus.sample_tick_out, bus.baud_tick_out, bus.mid_bit_tick_out, bus.sample_idx_out};
        check_int("midrun_reset_outputs_zero", c, 0);
        find_next(0, 20, at);  check_int("post_reset_first_tick", at, 4);
        wait_cyc(150); bus.resync_in = 1'b1; bus.inc_load_in = 1'b1; bus.inc_in = 8'd96;
        wait_cyc(151); bus.resync_in = 1'b0; bus.inc_load_in = 1'b0;
        find_next(0, 20, at);  check_int("resync_load_first_tick", at, 154);

        // Randomised traffic, checked every cycle by the model.
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            rst              = ($urandom_range(0, 499) == 0);
            bus.enable_in    = ($urandom_range(0, 9) != 0);
            bus.resync_in    = ($urandom_range(0, 99) == 0);
            bus.inc_load_in  = ($urandom_range(0, 59) == 0);
            sel = int'($urandom_range(0, 5));
            case (sel)
                0: bus.inc_in = 8'd0;
                1: bus.inc_in = 8'd1;
                2: bus.inc_in = 8'd255;
                3: bus.inc_in = 8'd128;
                default: bus.inc_in = 8'($urandom_range(0, 255));
            endcase
        end
        @(posedge clk); #1;
        rst = 1'b0; bus.resync_in = 1'b0; bus.inc_load_in = 1'b0; bus.enable_in = 1'b1;
        repeat (4) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
